// File: rtl/jk_pkg.sv
// Shared JK excitation encodings and the modulo next-value helper.
// Latency: n/a (package); no backpressure.
package jk_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Out-of-range values recover to 0 counting up and to modulo-1 counting down.
  function automatic logic [31:0] mod_next(input logic [31:0] cur,
                                           input logic        up,
                                           input logic [31:0] modulo);
    logic [31:0] nxt;
    if (up) nxt = (cur >= modulo - 32'd1) ? 32'd0 : cur + 32'd1;
    else    nxt = (cur == 32'd0 || cur >= modulo) ? modulo - 32'd1 : cur - 32'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/jk_ff_ar.sv
// Single JK flip-flop with asynchronous active-low clear.
// Latency: 1 clk from j/k to q; no backpressure.
module jk_ff_ar
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_SET:    q <= 1'b1;
        JK_RESET:  q <= 1'b0;
        JK_TOGGLE: q <= ~q;
        default:   q <= q;
      endcase
    end
  end

  assign qbar = ~q;

endmodule

// File: rtl/jk_counter.sv
// Modulo up/down counter: J/K excitation feeding a bank of JK flip-flops.
// Latency: 1 clk for load/count, tc combinational; no backpressure (sampled every edge).
module jk_counter
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned MODULO = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc
);

  logic [31:0]      q_ext;
  logic [31:0]      din_ext;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;

  assign q_ext   = {{(32-WIDTH){1'b0}}, q};
  assign din_ext = {{(32-WIDTH){1'b0}}, din};

  // Out-of-range load values are coerced to zero so the state stays legal.
  assign d = (din_ext < MODULO) ? din : '0;
  assign n = WIDTH'(mod_next(q_ext, up, MODULO));

  always_comb begin
    j = '0;
    k = '0;
    if (load) begin
      j = d;
      k = ~d;
    end else if (en) begin
      j = n & ~q;
      k = ~n & q;
    end
  end

  assign tc = en & ~load & ((up & (q_ext == MODULO - 1)) | (~up & (q_ext == 32'd0)));

  for (genvar i = 0; i < WIDTH; i++) begin : g_ff
    jk_ff_ar u_ff (
      .clk  (clk),
      .rst_n(rst_n),
      .j    (j[i]),
      .k    (k[i]),
      .q    (q[i]),
      .qbar (qbar[i])
    );
  end

endmodule
